// File: rtl/seg_scan_ctrl_pkg.sv
// Shared segment constants and polarity helper for the seg_scan_ctrl slice.
// Package seg_pkg: active-high GFEDCBA hex table, off pattern, slot phase enum.
package seg_pkg;

  typedef enum logic [0:0] {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic com_anode);
    return com_anode ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment pattern, with panel polarity applied.
module seg_hex_decode
  import seg_pkg::*;
#(
  parameter bit COM_ANODE = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = seg_polarity(SEG_HEX[nibble], COM_ANODE);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with per-frame input snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 16,
  parameter bit COM_ANODE   = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_IDLE   = seg_polarity(SEG_OFF, COM_ANODE);
  localparam logic              DP_IDLE    = COM_ANODE;
  localparam logic [DIGITS-1:0] DIG_IDLE   = {DIGITS{DIG_ACT_LOW}};

  logic [PW-1:0]       presc_r;
  logic [IW-1:0]       idx_r;
  logic                first_r;
  logic [4*DIGITS-1:0] shadow_value_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [DIGITS-1:0]   shadow_mask_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   dig_sel_r;
  logic                frame_start_r;

  logic                wrap_s;
  logic                frame_wrap_s;
  logic                snap_s;
  logic                show_s;
  slot_e               slot_s;
  logic [3:0]          nibble_s;
  logic [6:0]          dec_s;
  logic [DIGITS-1:0]   onehot_s;
  logic [DIGITS-1:0]   mask_next_s;

  assign wrap_s       = (presc_r == PRESC_LAST);
  assign frame_wrap_s = wrap_s && (idx_r == IDX_LAST);
  // first_r covers the very first enabled tick, when the shadows still hold reset zeros
  assign snap_s       = en && (first_r || frame_wrap_s);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign slot_s = SLOT_SHOW;
    end else begin : g_blank
      assign slot_s = (presc_r < PW'(BLANK_CYC)) ? SLOT_BLANK : SLOT_SHOW;
    end
  endgenerate

  assign nibble_s = shadow_value_r[{idx_r, 2'b00} +: 4];
  assign onehot_s = DIGITS'(1'b1) << idx_r;
  assign show_s   = en && !first_r && (slot_s == SLOT_SHOW) && !shadow_mask_r[idx_r];

  seg_hex_decode #(
    .COM_ANODE (COM_ANODE)
  ) u_dec (
    .nibble  (nibble_s),
    .pattern (dec_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_s;
  logic              lz_run_s;

  // Mark zero digits that sit above the most significant non-zero digit.
  always_comb begin
    lz_s     = '0;
    lz_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run_s = lz_run_s && (value[4*i +: 4] == 4'h0);
      lz_s[i]  = lz_run_s && !dp_in[i];
    end
  end

  assign mask_next_s = blank_mask | lz_s;
`else
  assign mask_next_s = blank_mask;
`endif

  // Scan position counters and once-per-frame input snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r        <= '0;
      idx_r          <= '0;
      first_r        <= 1'b1;
      shadow_value_r <= '0;
      shadow_dp_r    <= '0;
      shadow_mask_r  <= '0;
    end else if (en) begin
      presc_r <= wrap_s ? '0 : presc_r + 1'b1;
      if (wrap_s) begin
        idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
      end
      first_r <= 1'b0;
      if (snap_s) begin
        shadow_value_r <= value;
        shadow_dp_r    <= dp_in;
        shadow_mask_r  <= mask_next_s;
      end
    end
  end

  // Registered pin drivers: every output switches together on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r         <= SEG_IDLE;
      dp_r          <= DP_IDLE;
      dig_sel_r     <= DIG_IDLE;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= snap_s;
      seg_r         <= show_s ? dec_s : SEG_IDLE;
      dp_r          <= show_s ? (shadow_dp_r[idx_r] ^ COM_ANODE) : DP_IDLE;
      dig_sel_r     <= show_s ? (onehot_s ^ DIG_IDLE) : DIG_IDLE;
    end
  end

  assign seg         = seg_r;
  assign dp          = dp_r;
  assign dig_sel     = dig_sel_r;
  assign frame_start = frame_start_r;

endmodule
